inst_fetcher: RTL and testbench
===============================

# inst_fetcher

Front-end fetch stage that owns the program counter, issues single-outstanding instruction requests to the instruction cache, and pre-decodes each returned word. Conditional branches are presented to the branch predictor for a same-cycle taken/not-taken decision, which steers the next PC. Fetched instructions are buffered in an in-order queue for the decoder. A misprediction report from the branch predictor flushes the queue and redirects fetch.

## Interface
- `IQ_DEPTH`, 8: instruction queue entries; power of two, ≥2.
- `IQ_DEPTH_W`, 3: log2(`IQ_DEPTH`).
- `RESET_PC`, 32'h0: PC loaded on reset.

Ports:
- `clk_in` in 1: single clock; all state on rising edge.
- `rst_in` in 1: synchronous, active-low reset.
- `rdy_in` in 1: global ready; low freezes all state.
- `ic_req_valid` out 1: fetch request valid.
- `ic_req_addr` out 32: fetch address (current PC).
- `ic_req_ready` in 1: cache accepts request.
- `ic_resp_valid` in 1: one-cycle response pulse.
- `ic_resp_inst` in 32: returned instruction word.
- `bp_branch` out 1: conditional branch being presented this cycle.
- `bp_imm` out 32: sign-extended B-type immediate.
- `bp_pc` out 32: PC of the presented branch.
- `bp_need_branch` in 1: predictor says taken (combinational, same cycle).
- `bp_branch_addr` in 32: predicted target.
- `bp_predict_fail` in 1: earlier prediction was wrong.
- `bp_fail_addr` in 32: correct restart PC.
- `iq_valid` out 1: queue head valid.
- `iq_inst` out 32, `iq_pc` out 32, `iq_pred_taken` out 1: queue head contents.
- `iq_ready` in 1: decoder pops head when `iq_valid && iq_ready`.

## Operation
- FSM states:
  - IDLE: may request.
  - WAIT: request accepted, awaiting response.
  - DISCARD: flushed while a response is outstanding; the next response is dropped.
- IDLE:
  - `ic_req_valid = (count < IQ_DEPTH) && !bp_predict_fail`, with `ic_req_addr = pc`.
  - Handshake `valid && ready` moves to WAIT.
- WAIT with `ic_resp_valid`:
  - Pre-decode: opcode 7'b1100011 marks a branch.
  - For a branch, `bp_branch = 1`, `bp_pc = pc`, `bp_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}`.
  - Next pc = `bp_need_branch ? bp_branch_addr : pc + 4` (mod 2^32).
  - Push {inst, pc, taken} into the queue; go to IDLE.
- `bp_branch` is 0 in every other cycle. `bp_imm` and `bp_pc` are 0 when `bp_branch` is 0.
- Queue: circular buffer; front/rear wrap from `IQ_DEPTH-1` to 0; `count` ranges 0..`IQ_DEPTH`.
  - Push and pop in the same cycle leave `count` unchanged.
  - A push never overflows: a request is issued only when `count < IQ_DEPTH`, and only one request is ever outstanding.
- `bp_predict_fail` has priority over every other event:
  - Queue cleared (pointers and count to 0); any pop that cycle is ignored.
  - pc ← `bp_fail_addr`.
  - A response arriving the same cycle is dropped, `bp_branch` is forced to 0, and the state goes to IDLE.
  - In WAIT with no response, go to DISCARD.
  - In DISCARD, stay in DISCARD.
- DISCARD: on `ic_resp_valid`, drop the word and go to IDLE. `ic_req_valid` is 0.
- `rdy_in` low:
  - No state change; `ic_req_valid`, `bp_branch` and pops are suppressed.
  - The cache delivers no response while `rdy_in` is low.

## Timing
- Reset (`rst_in == 0` at an edge):
  - pc = `RESET_PC`, state IDLE, count 0.
  - Outputs: `ic_req_valid` 0 during reset, `iq_valid` 0, `bp_branch` 0, `iq_*` data 0.
  - Reset mid-WAIT abandons the request; a later stray response is ignored because the state is IDLE.
- Request to response: ≥1 cycle, set by the cache.
- Response to queue: the entry is visible at `iq_valid` the next cycle.
- Redirect:
  - The predicted target is requested at the earliest the cycle after the response.
  - `bp_fail_addr` is requested at the earliest the cycle after `bp_predict_fail`.
- `iq_valid = (count != 0)` is registered-state derived; `iq_*` show the head entry combinationally from the buffer.

## Configuration
- `IF_PREFETCH_EN`:
  - Defined: in WAIT, a response cycle may also raise `ic_req_valid` with the freshly computed next pc, provided `count + 1 < IQ_DEPTH` (counting the push) and no flush. If that request is accepted, the state stays WAIT. Sustains 1 instruction/cycle on a 1-cycle cache.
  - Undefined: a request is only issued from IDLE, so throughput is ≤1 instruction per 2 cycles.
  - All other behaviour is identical.

## Test plan
- Reset with `RESET_PC = 0x0`, cache 1-cycle, non-branch words:
  - First `ic_req_addr` 0x0, then 0x4, 0x8.
  - `iq_pc` sequence 0x0, 0x4, 0x8 with `iq_pred_taken = 0`.
- Branch word 0xFE000EE3 (beq, imm −4) at 0x10 with `bp_need_branch = 1`, `bp_branch_addr = 0xC`:
  - `bp_imm = 0xFFFFFFFC`; next request 0xC; entry `iq_pred_taken = 1`.
  - Repeat with taken = 0: next request 0x14.
- `iq_ready = 0` and 8 fetches:
  - count reaches 8 and `ic_req_valid` drops.
  - A single pop re-enables the request the next cycle.
  - Pointer wrap verified after 12 push/pop pairs.
- `bp_predict_fail = 1`, `bp_fail_addr = 0x100`, with 5 queued entries and a request outstanding:
  - `iq_valid` becomes 0 next cycle.
  - The outstanding response is dropped (DISCARD), then a request to 0x100 is issued.
- `bp_predict_fail` coincident with a branch response: `bp_branch` stays 0, no push, next request 0x100.
- `rdy_in` low for 3 cycles mid-WAIT, then high: pc, count and state are unchanged; normal completion follows.

Source files
------------

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - PC owner, single-outstanding I-cache fetch, branch pre-decode, in-order instruction queue
// Optional feature macro: IF_PREFETCH_EN (overlap the next request with the current response)
module inst_fetcher #(
    parameter int          IQ_DEPTH   = 8,
    parameter int          IQ_DEPTH_W = 3,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_req_ready,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,
    output logic        bp_branch,
    output logic [31:0] bp_imm,
    output logic [31:0] bp_pc,
    input  logic        bp_need_branch,
    input  logic [31:0] bp_branch_addr,
    input  logic        bp_predict_fail,
    input  logic [31:0] bp_fail_addr,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken,
    input  logic        iq_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    localparam logic [IQ_DEPTH_W:0] DEPTH_C = (IQ_DEPTH_W + 1)'(IQ_DEPTH);
    localparam logic [6:0]          OP_BRANCH = 7'b1100011;

    state_t                state;
    logic [31:0]           pc;
    logic [IQ_DEPTH_W-1:0] front;
    logic [IQ_DEPTH_W-1:0] rear;
    logic [IQ_DEPTH_W:0]   count;

    logic [31:0] inst_mem  [IQ_DEPTH];
    logic [31:0] pc_mem    [IQ_DEPTH];
    logic        taken_mem [IQ_DEPTH];

    logic        active;
    logic        resp_fire;
    logic        is_branch;
    logic        taken;
    logic [31:0] next_pc;
    logic        push;
    logic        pop;
    logic        idle_req;
    logic        prefetch;
    logic        req_fire;

    // Nothing moves while held in reset or while the global ready is low.
    assign active    = rst_in && rdy_in;
    assign resp_fire = active && (state == ST_WAIT) && ic_resp_valid;
    assign is_branch = (ic_resp_inst[6:0] == OP_BRANCH);

    assign bp_branch = resp_fire && is_branch && !bp_predict_fail;
    assign bp_pc     = bp_branch ? pc : 32'h0;
    assign bp_imm    = bp_branch ? {{20{ic_resp_inst[31]}}, ic_resp_inst[7],
                                    ic_resp_inst[30:25], ic_resp_inst[11:8], 1'b0}
                                 : 32'h0;

    assign taken   = bp_branch && bp_need_branch;
    assign next_pc = taken ? bp_branch_addr : (pc + 32'd4);

    assign push = resp_fire && !bp_predict_fail;
    assign pop  = active && iq_ready && (count != '0) && !bp_predict_fail;

    assign idle_req = active && (state == ST_IDLE) && (count < DEPTH_C) && !bp_predict_fail;

`ifdef IF_PREFETCH_EN
    // The request for the following word rides on the response cycle; leave room for this push.
    assign prefetch = push && ((count + {{IQ_DEPTH_W{1'b0}}, 1'b1}) < DEPTH_C);
`else
    assign prefetch = 1'b0;
`endif

    assign ic_req_valid = idle_req || prefetch;
    assign ic_req_addr  = prefetch ? next_pc : pc;
    assign req_fire     = ic_req_valid && ic_req_ready;

    assign iq_valid      = (count != '0);
    assign iq_inst       = iq_valid ? inst_mem[front]  : 32'h0;
    assign iq_pc         = iq_valid ? pc_mem[front]    : 32'h0;
    assign iq_pred_taken = iq_valid ? taken_mem[front] : 1'b0;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            front <= '0;
            rear  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (bp_predict_fail) begin
                pc    <= bp_fail_addr;
                front <= '0;
                rear  <= '0;
                count <= '0;
                // A response landing in the flush cycle is consumed here, so nothing is left to drop.
                case (state)
                    ST_IDLE: state <= ST_IDLE;
                    default: state <= ic_resp_valid ? ST_IDLE : ST_DISCARD;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req_fire)
                            state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (ic_resp_valid) begin
                            pc    <= next_pc;
                            state <= (prefetch && ic_req_ready) ? ST_WAIT : ST_IDLE;
                        end
                    end
                    ST_DISCARD: begin
                        if (ic_resp_valid)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase

                if (push)
                    rear <= rear + 1'b1;
                if (pop)
                    front <= front + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[rear]  <= ic_resp_inst;
            pc_mem[rear]    <= pc;
            taken_mem[rear] <= taken;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed self-checking bench for inst_fetcher
module tb_inst_fetcher;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ = 32'hFE00_0EE3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready = 1'b0;
    logic        ic_resp_valid = 1'b0;
    logic [31:0] ic_resp_inst = 32'h0;
    logic        bp_branch;
    logic [31:0] bp_imm;
    logic [31:0] bp_pc;
    logic        bp_need_branch = 1'b0;
    logic [31:0] bp_branch_addr = 32'h0;
    logic        bp_predict_fail = 1'b0;
    logic [31:0] bp_fail_addr = 32'h0;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pred_taken;
    logic        iq_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    inst_fetcher #(
        .IQ_DEPTH  (8),
        .IQ_DEPTH_W(3),
        .RESET_PC  (32'h0)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_inst   (ic_resp_inst),
        .bp_branch      (bp_branch),
        .bp_imm         (bp_imm),
        .bp_pc          (bp_pc),
        .bp_need_branch (bp_need_branch),
        .bp_branch_addr (bp_branch_addr),
        .bp_predict_fail(bp_predict_fail),
        .bp_fail_addr   (bp_fail_addr),
        .iq_valid       (iq_valid),
        .iq_inst        (iq_inst),
        .iq_pc          (iq_pc),
        .iq_pred_taken  (iq_pred_taken),
        .iq_ready       (iq_ready)
    );

    always #5 clk_in = ~clk_in;

    // Wait (bounded) for a request, accept it, return its address.
    task automatic issue(output logic ok, output logic [31:0] addr);
        ok = 1'b0;
        addr = 32'h0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (ic_req_valid) begin
                ok = 1'b1;
                addr = ic_req_addr;
                ic_req_ready = 1'b1;
            end
            @(negedge clk_in);
        end
        ic_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] inst, output logic br,
                           output logic [31:0] imm, output logic [31:0] bpc);
        ic_resp_valid = 1'b1;
        ic_resp_inst = inst;
        #1;
        br = bp_branch;
        imm = bp_imm;
        bpc = bp_pc;
        @(negedge clk_in);
        ic_resp_valid = 1'b0;
    endtask

    task automatic pop_one(output logic v, output logic [31:0] pc,
                           output logic [31:0] inst, output logic tk);
        iq_ready = 1'b1;
        #1;
        v = iq_valid;
        pc = iq_pc;
        inst = iq_inst;
        tk = iq_pred_taken;
        @(negedge clk_in);
        iq_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        checks++;
        if (ic_req_valid !== 1'b0 || iq_valid !== 1'b0 || bp_branch !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b iqv=%b br=%b exp 0 0 0", ic_req_valid, iq_valid, bp_branch);
        end
        checks++;
        if (iq_inst !== 32'h0 || iq_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_iq_data got inst=%h pc=%h exp 0 0", iq_inst, iq_pc);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req got v=%b a=%h exp 1 00000000", ic_req_valid, ic_req_addr);
        end
        @(negedge clk_in);
    endtask

    task automatic test_sequential();
        logic ok, br, v, tk;
        logic [31:0] a, imm, bpc, p, ins;
        iq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(ok, a);
            checks++;
            if (ok !== 1'b1 || a !== 32'(i * 4)) begin
                errors++;
                $display("FAIL seq_req_addr got ok=%b a=%h exp %h", ok, a, 32'(i * 4));
            end
            respond(NOP, br, imm, bpc);
            checks++;
            if (br !== 1'b0 || imm !== 32'h0 || bpc !== 32'h0) begin
                errors++;
                $display("FAIL seq_no_branch got br=%b imm=%h pc=%h exp 0 0 0", br, imm, bpc);
            end
        end
        for (int i = 0; i < 3; i++) begin
            pop_one(v, p, ins, tk);
            checks++;
            if (v !== 1'b1 || p !== 32'(i * 4) || tk !== 1'b0 || ins !== NOP) begin
                errors++;
                $display("FAIL seq_pop got v=%b pc=%h tk=%b inst=%h exp 1 %h 0 %h", v, p, tk, ins, 32'(i * 4), NOP);
            end
        end
        #1;
        checks++;
        if (iq_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_empty got iq_valid=%b exp 0", iq_valid);
        end
        @(negedge clk_in);
    endtask

    task automatic test_branch();
        logic ok, br, v, tk;
        logic [31:0] a, imm, bpc, p, ins;
        logic [31:0] exp_pc [5];
        logic        exp_tk [5];
        exp_pc = '{32'hC, 32'h10, 32'hC, 32'h10, 32'h14};
        exp_tk = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        issue(ok, a);
        respond(NOP, br, imm, bpc);
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h10) begin
            errors++;
            $display("FAIL br_req_10 got ok=%b a=%h exp 00000010", ok, a);
        end
        bp_need_branch = 1'b1;
        bp_branch_addr = 32'hC;
        respond(BEQ, br, imm, bpc);
        bp_need_branch = 1'b0;
        checks++;
        if (br !== 1'b1 || imm !== 32'hFFFF_FFFC || bpc !== 32'h10) begin
            errors++;
            $display("FAIL br_present got br=%b imm=%h pc=%h exp 1 fffffffc 00000010", br, imm, bpc);
        end
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'hC) begin
            errors++;
            $display("FAIL br_taken_target got ok=%b a=%h exp 0000000c", ok, a);
        end
        respond(NOP, br, imm, bpc);
        issue(ok, a);
        respond(BEQ, br, imm, bpc);
        checks++;
        if (br !== 1'b1 || bpc !== 32'h10) begin
            errors++;
            $display("FAIL br_present2 got br=%b pc=%h exp 1 00000010", br, bpc);
        end
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h14) begin
            errors++;
            $display("FAIL br_not_taken_next got ok=%b a=%h exp 00000014", ok, a);
        end
        respond(NOP, br, imm, bpc);
        for (int i = 0; i < 5; i++) begin
            pop_one(v, p, ins, tk);
            checks++;
            if (v !== 1'b1 || p !== exp_pc[i] || tk !== exp_tk[i]) begin
                errors++;
                $display("FAIL br_pop got v=%b pc=%h tk=%b exp 1 %h %b", v, p, tk, exp_pc[i], exp_tk[i]);
            end
        end
    endtask

    task automatic test_full_and_wrap();
        logic ok, br, v, tk;
        logic [31:0] a, imm, bpc, p, ins;
        iq_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(ok, a);
            respond(NOP, br, imm, bpc);
        end
        #1;
        checks++;
        if (ic_req_valid !== 1'b0 || iq_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_req_drop got req=%b iqv=%b exp 0 1", ic_req_valid, iq_valid);
        end
        @(negedge clk_in);
        #1;
        checks++;
        if (ic_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_req_hold got req=%b exp 0", ic_req_valid);
        end
        pop_one(v, p, ins, tk);
        checks++;
        if (v !== 1'b1 || p !== 32'h18) begin
            errors++;
            $display("FAIL full_first_pop got v=%b pc=%h exp 1 00000018", v, p);
        end
        #1;
        checks++;
        if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h38) begin
            errors++;
            $display("FAIL full_reenable got req=%b a=%h exp 1 00000038", ic_req_valid, ic_req_addr);
        end
        for (int j = 0; j < 12; j++) begin
            issue(ok, a);
            checks++;
            if (ok !== 1'b1 || a !== 32'h38 + 32'(4 * j)) begin
                errors++;
                $display("FAIL wrap_req got ok=%b a=%h exp %h", ok, a, 32'h38 + 32'(4 * j));
            end
            respond(NOP, br, imm, bpc);
            pop_one(v, p, ins, tk);
            checks++;
            if (v !== 1'b1 || p !== 32'h18 + 32'(4 * (j + 1))) begin
                errors++;
                $display("FAIL wrap_pop got v=%b pc=%h exp %h", v, p, 32'h18 + 32'(4 * (j + 1)));
            end
        end
        for (int k = 0; k < 7; k++) begin
            pop_one(v, p, ins, tk);
            checks++;
            if (v !== 1'b1 || p !== 32'h18 + 32'(4 * (13 + k))) begin
                errors++;
                $display("FAIL drain_pop got v=%b pc=%h exp %h", v, p, 32'h18 + 32'(4 * (13 + k)));
            end
        end
        #1;
        checks++;
        if (iq_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got iq_valid=%b exp 0", iq_valid);
        end
        @(negedge clk_in);
    endtask

    task automatic test_flush();
        logic ok, br, v, tk;
        logic [31:0] a, imm, bpc, p, ins;
        for (int i = 0; i < 5; i++) begin
            issue(ok, a);
            respond(NOP, br, imm, bpc);
        end
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h7C) begin
            errors++;
            $display("FAIL flush_outstanding got ok=%b a=%h exp 0000007c", ok, a);
        end
        bp_predict_fail = 1'b1;
        bp_fail_addr = 32'h100;
        #1;
        checks++;
        if (ic_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_block got req=%b exp 0", ic_req_valid);
        end
        @(negedge clk_in);
        bp_predict_fail = 1'b0;
        #1;
        checks++;
        if (iq_valid !== 1'b0 || ic_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got iqv=%b req=%b exp 0 0", iq_valid, ic_req_valid);
        end
        respond(BEQ, br, imm, bpc);
        checks++;
        if (br !== 1'b0) begin
            errors++;
            $display("FAIL discard_no_branch got br=%b exp 0", br);
        end
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h100) begin
            errors++;
            $display("FAIL flush_redirect got ok=%b a=%h exp 00000100", ok, a);
        end
        respond(NOP, br, imm, bpc);
        pop_one(v, p, ins, tk);
        checks++;
        if (v !== 1'b1 || p !== 32'h100 || ins !== NOP) begin
            errors++;
            $display("FAIL flush_entry got v=%b pc=%h inst=%h exp 1 00000100 %h", v, p, ins, NOP);
        end
        #1;
        checks++;
        if (iq_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale_dropped got iq_valid=%b exp 0", iq_valid);
        end
        @(negedge clk_in);
    endtask

    task automatic test_fail_with_resp();
        logic ok, br, v, tk;
        logic [31:0] a, imm, bpc, p, ins;
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h104) begin
            errors++;
            $display("FAIL fwr_req got ok=%b a=%h exp 00000104", ok, a);
        end
        bp_need_branch = 1'b1;
        bp_branch_addr = 32'h40;
        bp_predict_fail = 1'b1;
        bp_fail_addr = 32'h100;
        respond(BEQ, br, imm, bpc);
        bp_predict_fail = 1'b0;
        bp_need_branch = 1'b0;
        checks++;
        if (br !== 1'b0 || imm !== 32'h0) begin
            errors++;
            $display("FAIL fwr_branch_forced got br=%b imm=%h exp 0 0", br, imm);
        end
        #1;
        checks++;
        if (iq_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwr_no_push got iq_valid=%b exp 0", iq_valid);
        end
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h100) begin
            errors++;
            $display("FAIL fwr_redirect got ok=%b a=%h exp 00000100", ok, a);
        end
        respond(NOP, br, imm, bpc);
        pop_one(v, p, ins, tk);
        checks++;
        if (v !== 1'b1 || p !== 32'h100) begin
            errors++;
            $display("FAIL fwr_entry got v=%b pc=%h exp 1 00000100", v, p);
        end
    endtask

    task automatic test_rdy_stall();
        logic ok, br, v, tk;
        logic [31:0] a, imm, bpc, p, ins;
        issue(ok, a);
        respond(NOP, br, imm, bpc);
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h108) begin
            errors++;
            $display("FAIL rdy_req got ok=%b a=%h exp 00000108", ok, a);
        end
        rdy_in = 1'b0;
        iq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ic_req_valid !== 1'b0 || iq_valid !== 1'b1 || iq_pc !== 32'h104) begin
                errors++;
                $display("FAIL rdy_frozen got req=%b iqv=%b pc=%h exp 0 1 00000104", ic_req_valid, iq_valid, iq_pc);
            end
            @(negedge clk_in);
        end
        rdy_in = 1'b1;
        iq_ready = 1'b0;
        respond(NOP, br, imm, bpc);
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h10C) begin
            errors++;
            $display("FAIL rdy_resume got ok=%b a=%h exp 0000010c", ok, a);
        end
        pop_one(v, p, ins, tk);
        checks++;
        if (v !== 1'b1 || p !== 32'h104) begin
            errors++;
            $display("FAIL rdy_pop0 got v=%b pc=%h exp 1 00000104", v, p);
        end
        pop_one(v, p, ins, tk);
        checks++;
        if (v !== 1'b1 || p !== 32'h108) begin
            errors++;
            $display("FAIL rdy_pop1 got v=%b pc=%h exp 1 00000108", v, p);
        end
    endtask

    task automatic test_reset_midwait();
        logic ok, br, v, tk;
        logic [31:0] a, imm, bpc, p, ins;
        rst_in = 1'b0;
        #1;
        checks++;
        if (ic_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_req got req=%b exp 0", ic_req_valid);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        respond(NOP, br, imm, bpc);
        #1;
        checks++;
        if (iq_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stray_resp got iq_valid=%b exp 0", iq_valid);
        end
        issue(ok, a);
        checks++;
        if (ok !== 1'b1 || a !== 32'h0) begin
            errors++;
            $display("FAIL rst_restart got ok=%b a=%h exp 00000000", ok, a);
        end
        respond(NOP, br, imm, bpc);
        pop_one(v, p, ins, tk);
        checks++;
        if (v !== 1'b1 || p !== 32'h0) begin
            errors++;
            $display("FAIL rst_entry got v=%b pc=%h exp 1 00000000", v, p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_full_and_wrap();
        test_flush();
        test_fail_with_resp();
        test_rdy_stall();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
